xdma_grant_arbiter: RTL and testbench



---
 rtl/xdma_pkg.sv | 23 ++
 rtl/xdma_grant_arbiter_rr_select.sv | 28 ++
 rtl/xdma_grant_arbiter.sv | 96 +++++++++
 tb/tb_xdma_grant_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xdma_pkg.sv
// Shared XDMA types and defaults.
// Grant payload and descriptor bundles plus arbiter defaults.
package xdma_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  id;
    } xdma_to_remote_grant_t;

    typedef struct packed {
        logic [15:0] len;
        logic [3:0]  tag;
    } xdma_req_desc_t;

    localparam int XdmaGrantArbDefaultReq = 4;
    localparam int XdmaGrantStallLimit    = 1024;

    typedef enum logic {
        ArbIdle,
        ArbHold
    } xdma_arb_state_e;

endpackage

// File: rtl/xdma_grant_arbiter_rr_select.sv
// Round-robin find-first-set starting at a priority pointer.
// Purely combinational; wraps modulo NumReq.
module xdma_rr_select #(
    parameter int NumReq = 4,
    localparam int IdxW = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] valid,
    input  logic [IdxW-1:0]   ptr,
    output logic [IdxW-1:0]   win,
    output logic              found
);

    int k;

    always_comb begin
        win   = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 0; i < NumReq; i++) begin
            k = (int'(ptr) + i) % NumReq;
            if (!found && valid[k[IdxW-1:0]]) begin
                found = 1'b1;
                win   = k[IdxW-1:0];
            end
        end
    end

endmodule

// File: rtl/xdma_grant_arbiter.sv
// Round-robin arbiter onto the shared to-remote grant channel.
// Registered output held until accepted; grant counter and stall watchdog.
module xdma_grant_arbiter
    import xdma_pkg::*;
#(
    parameter int  NumReq                 = XdmaGrantArbDefaultReq,
    parameter type xdma_to_remote_grant_t = logic,
    parameter type xdma_req_desc_t        = logic,
    parameter int  StallLimit             = XdmaGrantStallLimit,
    parameter int  CntWidth               = 16,
    localparam int IdxW                   = $clog2(NumReq)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NumReq-1:0]     req_valid_i,
    output logic [NumReq-1:0]     req_ready_o,
    input  xdma_to_remote_grant_t req_grant_i [NumReq],
    input  xdma_req_desc_t        req_desc_i  [NumReq],
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output xdma_to_remote_grant_t out_grant_o,
    output xdma_req_desc_t        out_desc_o,
    output logic [IdxW-1:0]       out_idx_o,
    output logic [CntWidth-1:0]   grant_cnt_o,
    output logic                  stall_o
);

    localparam int SW = $clog2(StallLimit + 1);

    xdma_arb_state_e state;
    logic [IdxW-1:0] ptr;
    logic [IdxW-1:0] win;
    logic            found;
    logic            sel_en;
    logic            hs;
    logic [SW-1:0]   stall_cnt;

    xdma_rr_select #(
        .NumReq (NumReq)
    ) u_sel (
        .valid (req_valid_i),
        .ptr   (ptr),
        .win   (win),
        .found (found)
    );

    assign hs     = (state == ArbHold) && out_ready_i;
    assign sel_en = (state == ArbIdle) || out_ready_i;

    always_comb begin
        req_ready_o = '0;
        if (!rst_i && sel_en && found) begin
            req_ready_o[win] = 1'b1;
        end
    end

    // Sticky until the counter is cleared by a handshake.
    assign stall_o = (stall_cnt == SW'(StallLimit));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ArbIdle;
            ptr         <= '0;
            out_valid_o <= 1'b0;
            out_grant_o <= '0;
            out_desc_o  <= '0;
            out_idx_o   <= '0;
            grant_cnt_o <= '0;
            stall_cnt   <= '0;
        end else begin
            if (hs) begin
                grant_cnt_o <= grant_cnt_o + CntWidth'(1);
            end
            if (sel_en) begin
                if (found) begin
                    state       <= ArbHold;
                    out_valid_o <= 1'b1;
                    out_grant_o <= req_grant_i[win];
                    out_desc_o  <= req_desc_i[win];
                    out_idx_o   <= win;
                    ptr         <= (win == IdxW'(NumReq - 1)) ? '0
                                   : win + IdxW'(1);
                end else begin
                    state       <= ArbIdle;
                    out_valid_o <= 1'b0;
                end
            end
            if (hs) begin
                stall_cnt <= '0;
            end else if (state == ArbHold && !stall_o) begin
                stall_cnt <= stall_cnt + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_xdma_grant_arbiter.sv
// Directed scoreboard bench for xdma_grant_arbiter.
// Stimulus pushes expected grants; a monitor pops them on output handshakes.
module tb_xdma_grant_arbiter;
    import xdma_pkg::*;

    localparam int N  = 4;
    localparam int IW = 2;

    typedef struct packed {
        logic [IW-1:0]         idx;
        xdma_to_remote_grant_t g;
        xdma_req_desc_t        d;
    } exp_t;

    logic                  clk;
    logic                  rst;
    logic [N-1:0]          req_valid;
    logic [N-1:0]          req_ready;
    xdma_to_remote_grant_t req_grant [N];
    xdma_req_desc_t        req_desc  [N];
    logic                  out_valid;
    logic                  out_ready;
    xdma_to_remote_grant_t out_grant;
    xdma_req_desc_t        out_desc;
    logic [IW-1:0]         out_idx;
    logic [3:0]            grant_cnt;
    logic                  stall;

    exp_t exp_q[$];
    exp_t e;
    int   ver [N];
    int   n_pass  = 0;
    int   n_total = 0;
    xdma_to_remote_grant_t g_hold;

    xdma_grant_arbiter #(
        .NumReq                 (N),
        .xdma_to_remote_grant_t (xdma_to_remote_grant_t),
        .xdma_req_desc_t        (xdma_req_desc_t),
        .StallLimit             (8),
        .CntWidth               (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_grant_i (req_grant),
        .req_desc_i  (req_desc),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_grant_o (out_grant),
        .out_desc_o  (out_desc),
        .out_idx_o   (out_idx),
        .grant_cnt_o (grant_cnt),
        .stall_o     (stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    function automatic xdma_to_remote_grant_t mk_g(int k, int v);
        mk_g.addr = 32'hA000_0000 + 32'(k * 256 + v);
        mk_g.id   = 8'(k * 16 + v);
    endfunction

    function automatic xdma_req_desc_t mk_d(int k, int v);
        mk_d.len = 16'(100 * k + v + 1);
        mk_d.tag = 4'(k + v);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] expv);
        n_total++;
        if (act !== expv)
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        else
            n_pass++;
    endtask

    task automatic set_pay(input int k);
        req_grant[k] = mk_g(k, ver[k]);
        req_desc[k]  = mk_d(k, ver[k]);
    endtask

    task automatic push(input int k);
        exp_q.push_back('{idx: IW'(k), g: mk_g(k, ver[k]),
                          d: mk_d(k, ver[k])});
    endtask

    task automatic bump(input int k);
        ver[k]++;
        set_pay(k);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string t);
        chk({t, "_valid"}, 64'(out_valid), 64'd0);
        chk({t, "_grant"}, 64'(out_grant), 64'd0);
        chk({t, "_desc"}, 64'(out_desc), 64'd0);
        chk({t, "_idx"}, 64'(out_idx), 64'd0);
        chk({t, "_cnt"}, 64'(grant_cnt), 64'd0);
        chk({t, "_stall"}, 64'(stall), 64'd0);
        chk({t, "_rdy"}, 64'(req_ready), 64'd0);
        chk({t, "_ptr"}, 64'(dut.ptr), 64'd0);
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        req_valid = '0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_idx", 64'(out_idx), 64'(e.idx));
                chk("sb_grant", 64'(out_grant), 64'(e.g));
                chk("sb_desc", 64'(out_desc), 64'(e.d));
            end
        end
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            ver[k] = 0;
            set_pay(k);
        end
        rst       = 1'b1;
        req_valid = '1;
        out_ready = 1'b0;
        step();
        @(negedge clk);
        check_reset("rst");
        req_valid = '0;
        rst       = 1'b0;

        // single request
        step();
        req_valid = 4'b0100;
        out_ready = 1'b1;
        push(2);
        @(negedge clk);
        chk("single_rdy", 64'(req_ready), 64'b0100);
        chk("single_v0", 64'(out_valid), 64'd0);
        step();
        req_valid = '0;
        bump(2);
        @(negedge clk);
        chk("single_v1", 64'(out_valid), 64'd1);
        chk("single_idx", 64'(out_idx), 64'd2);
        step();
        @(negedge clk);
        chk("single_cnt", 64'(grant_cnt), 64'd1);
        chk("single_ptr", 64'(dut.ptr), 64'd3);
        chk("single_v2", 64'(out_valid), 64'd0);

        // round robin
        do_reset();
        req_valid = '1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            push(c % N);
            @(negedge clk);
            chk("rr_rdy", 64'(req_ready), 64'(1 << (c % N)));
            if (c > 0) chk("rr_valid", 64'(out_valid), 64'd1);
            step();
            bump(c % N);
        end
        req_valid = '0;
        @(negedge clk);
        chk("rr_valid_last", 64'(out_valid), 64'd1);
        step();
        @(negedge clk);
        chk("rr_cnt", 64'(grant_cnt), 64'd5);
        chk("rr_idle", 64'(out_valid), 64'd0);

        // backpressure
        do_reset();
        req_valid = 4'b1010;
        out_ready = 1'b0;
        push(1);
        g_hold = mk_g(1, ver[1]);
        @(negedge clk);
        chk("bp_rdy0", 64'(req_ready), 64'b0010);
        step();
        req_valid = 4'b1000;
        bump(1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_idx", 64'(out_idx), 64'd1);
            chk("bp_grant", 64'(out_grant), 64'(g_hold));
            chk("bp_rdy", 64'(req_ready), 64'd0);
            step();
        end
        out_ready = 1'b1;
        push(3);
        @(negedge clk);
        chk("bp_rdy3", 64'(req_ready), 64'b1000);
        step();
        req_valid = '0;
        bump(3);
        @(negedge clk);
        chk("bp_valid3", 64'(out_valid), 64'd1);
        chk("bp_idx3", 64'(out_idx), 64'd3);
        step();
        out_ready = 1'b0;

        // watchdog
        do_reset();
        req_valid = 4'b0001;
        push(0);
        step();
        req_valid = '0;
        bump(0);
        @(negedge clk);
        chk("wd_valid", 64'(out_valid), 64'd1);
        chk("wd_t0", 64'(stall), 64'd0);
        for (int i = 1; i < 8; i++) begin
            step();
            @(negedge clk);
            chk("wd_low", 64'(stall), 64'd0);
        end
        step();
        @(negedge clk);
        chk("wd_rise", 64'(stall), 64'd1);
        step();
        @(negedge clk);
        chk("wd_sat", 64'(stall), 64'd1);
        step();
        out_ready = 1'b1;
        @(negedge clk);
        chk("wd_hs", 64'(stall), 64'd1);
        step();
        out_ready = 1'b0;
        @(negedge clk);
        chk("wd_clr", 64'(stall), 64'd0);
        chk("wd_idle", 64'(out_valid), 64'd0);

        // counter wrap
        do_reset();
        req_valid = 4'b0001;
        out_ready = 1'b1;
        for (int n = 0; n < 17; n++) begin
            push(0);
            step();
            bump(0);
        end
        req_valid = '0;
        step();
        @(negedge clk);
        chk("wrap_cnt", 64'(grant_cnt), 64'd1);

        // reset while holding
        out_ready = 1'b0;
        req_valid = 4'b0010;
        step();
        @(negedge clk);
        chk("mid_hold", 64'(out_valid), 64'd1);
        rst = 1'b1;
        step();
        @(negedge clk);
        check_reset("mid");
        rst       = 1'b0;
        req_valid = '0;
        step();
        step();
        chk("sb_left", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
